// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU command sequencer.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_B    = 3'd1,
    S_GET_OP   = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_ALU = 3'd4,
    S_SEND_HI  = 3'd5,
    S_SEND_LO  = 3'd6,
    S_SEND_ERR = 3'd7
  } state_t;

  localparam logic [7:0] ERR_CODE_DEFAULT  = 8'hEE;
  // Only the low two bits may be set in a legal opcode byte.
  localparam logic [7:0] OPCODE_VALID_MASK = 8'hFC;

  function automatic logic opcode_ok(input logic [7:0] op_byte);
    return (op_byte & OPCODE_VALID_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags when CYCLES-1 is reached.
module byte_timeout #(
  parameter int unsigned CYCLES = 208000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = ($clog2(CYCLES) < 1) ? 1 : $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  assign expired = (count == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, runs the
// external ALU and returns the 16-bit result (or an error byte) over UART TX.
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 208000,
  parameter logic [7:0]  ERR_CODE       = ERR_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [2:0]  state,
  output logic        overrun,
  output logic        err
);

  state_t      cur_state, nxt_state;
  logic [15:0] result;
  logic        issued;
  logic        in_cmd, in_body, byte_ok, op_bad, expired;
  logic        in_send, send_fire, send_done;

  assign in_cmd  = (cur_state == S_IDLE) || (cur_state == S_GET_B) || (cur_state == S_GET_OP);
  assign in_body = (cur_state == S_GET_B) || (cur_state == S_GET_OP);
  assign byte_ok = in_cmd && rx_valid && !rx_frame_err;
  assign op_bad  = (cur_state == S_GET_OP) && byte_ok && !opcode_ok(rx_data);
  assign in_send = (cur_state == S_SEND_HI) || (cur_state == S_SEND_LO) || (cur_state == S_SEND_ERR);

  assign send_fire = in_send && !issued && !tx_busy;
  // The cycle carrying tx_start is skipped so a transmitter that raises busy
  // one clock late is not mistaken for an idle line.
  assign send_done = in_send && issued && !tx_start && !tx_busy;

  assign state = cur_state;

  byte_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (byte_ok || !in_body),
    .en      (in_body),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE: begin
        if (rx_frame_err)  nxt_state = S_SEND_ERR;
        else if (rx_valid) nxt_state = S_GET_B;
      end
      S_GET_B: begin
        if (rx_frame_err)  nxt_state = S_SEND_ERR;
        else if (rx_valid) nxt_state = S_GET_OP;
        else if (expired)  nxt_state = S_IDLE;
      end
      S_GET_OP: begin
        if (rx_frame_err)  nxt_state = S_SEND_ERR;
        else if (rx_valid) nxt_state = opcode_ok(rx_data) ? S_EXEC : S_SEND_ERR;
        else if (expired)  nxt_state = S_IDLE;
      end
      S_EXEC:     nxt_state = S_WAIT_ALU;
      S_WAIT_ALU: if (alu_done)  nxt_state = S_SEND_HI;
      S_SEND_HI:  if (send_done) nxt_state = S_SEND_LO;
      S_SEND_LO:  if (send_done) nxt_state = S_IDLE;
      S_SEND_ERR: if (send_done) nxt_state = S_IDLE;
      default:    nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (cur_state)
      S_SEND_HI:  tx_data = result[15:8];
      S_SEND_LO:  tx_data = result[7:0];
      S_SEND_ERR: tx_data = ERR_CODE;
      default:    tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 2'b00;
      alu_start <= 1'b0;
      tx_start  <= 1'b0;
      issued    <= 1'b0;
      result    <= 16'h0000;
      overrun   <= 1'b0;
      err       <= 1'b0;
    end else begin
      alu_start <= (cur_state == S_EXEC);
      tx_start  <= send_fire;
      issued    <= send_fire || (issued && !send_done);

      if (byte_ok) begin
        case (cur_state)
          S_IDLE:   alu_a <= rx_data;
          S_GET_B:  alu_b <= rx_data;
          S_GET_OP: if (opcode_ok(rx_data)) alu_op <= rx_data[1:0];
          default:  ;
        endcase
      end

      if ((cur_state == S_WAIT_ALU) && alu_done) result <= alu_result;
      if (rx_valid && !in_cmd)                   overrun <= 1'b1;
      if ((in_cmd && rx_frame_err) || op_bad)    err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed, table-driven bench for uart_alu_sequencer with small ALU and UART TX models.
module tb_uart_alu_sequencer;
  import uart_alu_pkg::*;

  localparam int TOUT   = 40;
  localparam int TX_LEN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_frame_err = 1'b0;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [1:0]  alu_op;
  logic        alu_start, tx_start, overrun, err;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        tx_busy;
  logic        tx_busy_model = 1'b0;
  logic        hold_busy = 1'b0;
  logic [2:0]  state;

  assign tx_busy = tx_busy_model | hold_busy;

  uart_alu_sequencer #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .state(state), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU model: op 0 add, 1 sub, 2 mul, 3 and; answers alu_lat cycles after alu_start.
  int n_start = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int alu_lat = 2;
  always @(negedge clk) begin
    if (alu_start) begin
      logic [7:0] a, b;
      logic [1:0] op;
      a = alu_a; b = alu_b; op = alu_op;
      n_start++;
      start_cyc = cyc;
      repeat (alu_lat) @(negedge clk);
      case (op)
        2'd0: alu_result = 16'(a) + 16'(b);
        2'd1: alu_result = 16'(a) - 16'(b);
        2'd2: alu_result = 16'(a) * 16'(b);
        default: alu_result = 16'(a & b);
      endcase
      alu_done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      alu_done = 1'b0;
    end
  end

  // UART TX model: records each tx_start and stays busy for TX_LEN cycles.
  int n_tx = 0;
  int tx_cnt = 0;
  logic [7:0] tx_q[$];
  int tx_cyc_q[$];
  always @(negedge clk) begin
    if (tx_start) begin
      n_tx++;
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
      tx_cnt = TX_LEN;
      tx_busy_model = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_busy_model = 1'b0;
    end
  end

  function automatic logic [7:0] tx_byte(input int i);
    return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
  endfunction

  function automatic int tx_cyc(input int i);
    return (tx_cyc_q.size() > i) ? tx_cyc_q[i] : -1;
  endfunction

  int last_rx_cyc = 0;
  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    rx_frame_err = fe;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (state == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  op;
    logic [15:0] res;
    logic        bad;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok;
    int n_s0, n_t0, op_cyc;
    logic [7:0] exp_a, exp_b;
    logic [1:0] exp_op;
    logic err_exp;

    vecs[0] = '{8'h35, 8'h02, 8'h00, 16'h0037, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 16'h0100, 1'b0};
    vecs[2] = '{8'h10, 8'h03, 8'h01, 16'h000D, 1'b0};
    vecs[3] = '{8'h0F, 8'h11, 8'h02, 16'h00FF, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'h02, 16'hFE01, 1'b0};
    vecs[5] = '{8'hF0, 8'h3C, 8'h03, 16'h0030, 1'b0};
    vecs[6] = '{8'h01, 8'h02, 8'h03, 16'h0000, 1'b0};
    vecs[7] = '{8'h35, 8'h02, 8'h80, 16'h0000, 1'b1};
    vecs[8] = '{8'h01, 8'h02, 8'h04, 16'h0000, 1'b1};

    exp_a = 8'h00; exp_b = 8'h00; exp_op = 2'b00; err_exp = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_pulses", {alu_start, tx_start}, 2'b00);
    check("rst_flags", {overrun, err}, 2'b00);
    rst_n = 1'b1;

    // Table-driven commands
    for (int i = 0; i < 9; i++) begin
      n_s0 = n_start; n_t0 = n_tx;
      tx_q.delete(); tx_cyc_q.delete();
      send_byte(vecs[i].a, 1'b0);
      send_byte(vecs[i].b, 1'b0);
      send_byte(vecs[i].op, 1'b0);
      op_cyc = last_rx_cyc;
      wait_state(S_IDLE, 200, ok);
      check($sformatf("v%0d_idle", i), ok, 1);
      exp_a = vecs[i].a; exp_b = vecs[i].b;
      if (!vecs[i].bad) begin
        exp_op = vecs[i].op[1:0];
        check($sformatf("v%0d_starts", i), n_start - n_s0, 1);
        check($sformatf("v%0d_txs", i), n_tx - n_t0, 2);
        check($sformatf("v%0d_tx_hi", i), tx_byte(0), vecs[i].res[15:8]);
        check($sformatf("v%0d_tx_lo", i), tx_byte(1), vecs[i].res[7:0]);
        check($sformatf("v%0d_lat_start", i), start_cyc - op_cyc, 2);
        check($sformatf("v%0d_lat_tx", i), tx_cyc(0) - done_cyc, 2);
      end else begin
        err_exp = 1'b1;
        check($sformatf("v%0d_starts", i), n_start - n_s0, 0);
        check($sformatf("v%0d_txs", i), n_tx - n_t0, 1);
        check($sformatf("v%0d_tx_err", i), tx_byte(0), 8'hEE);
      end
      check($sformatf("v%0d_alu_a", i), alu_a, exp_a);
      check($sformatf("v%0d_alu_b", i), alu_b, exp_b);
      check($sformatf("v%0d_alu_op", i), alu_op, exp_op);
      check($sformatf("v%0d_err", i), err, err_exp);
    end

    // Timeout after one byte, then a normal command
    n_t0 = n_tx;
    send_byte(8'h35, 1'b0);
    repeat (TOUT - 1) @(negedge clk);
    check("tout_before", state, S_GET_B);
    @(negedge clk);
    check("tout_after", state, S_IDLE);
    check("tout_no_tx", n_tx - n_t0, 0);
    check("tout_err", err, err_exp);
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h35, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    wait_state(S_IDLE, 200, ok);
    check("tout_next_idle", ok, 1);
    check("tout_next_hi", tx_byte(0), 8'h00);
    check("tout_next_lo", tx_byte(1), 8'h37);
    exp_a = 8'h35; exp_b = 8'h02; exp_op = 2'd0;

    // Byte arriving during WAIT_ALU is dropped and flagged
    alu_lat = 20;
    check("ovr_before", overrun, 1'b0);
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h22, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("ovr_in_wait", state, S_WAIT_ALU);
    send_byte(8'h99, 1'b0);
    check("ovr_set", overrun, 1'b1);
    check("ovr_state", state, S_WAIT_ALU);
    wait_state(S_IDLE, 200, ok);
    check("ovr_idle", ok, 1);
    check("ovr_tx_hi", tx_byte(0), 8'h00);
    check("ovr_tx_lo", tx_byte(1), 8'h33);
    check("ovr_alu_a", alu_a, 8'h22);
    alu_lat = 2;

    // tx_busy held high through SEND_HI
    hold_busy = 1'b1;
    n_t0 = n_tx;
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h40, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h02, 1'b0);
    wait_state(S_SEND_HI, 50, ok);
    check("busy_in_hi", ok, 1);
    repeat (500) @(negedge clk);
    check("busy_deferred", n_tx - n_t0, 0);
    hold_busy = 1'b0;
    wait_state(S_IDLE, 200, ok);
    check("busy_idle", ok, 1);
    check("busy_two_tx", n_tx - n_t0, 2);
    check("busy_tx_hi", tx_byte(0), 8'h00);
    check("busy_tx_lo", tx_byte(1), 8'h80);
    exp_b = 8'h02;

    // Frame error in GET_B with simultaneous rx_valid
    n_s0 = n_start; n_t0 = n_tx;
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    check("fe_state", state, S_SEND_ERR);
    wait_state(S_IDLE, 200, ok);
    check("fe_idle", ok, 1);
    check("fe_tx", tx_byte(0), 8'hEE);
    check("fe_txs", n_tx - n_t0, 1);
    check("fe_no_start", n_start - n_s0, 0);
    check("fe_alu_b_kept", alu_b, exp_b);
    check("fe_err", err, 1'b1);

    // Reset asserted in SEND_LO
    n_t0 = n_tx;
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h35, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    wait_state(S_SEND_LO, 200, ok);
    check("mid_in_lo", ok, 1);
    rst_n = 1'b0;
    #1;
    check("mid_state", state, S_IDLE);
    check("mid_operands", {alu_a, alu_b, 6'd0, alu_op}, 32'h0);
    check("mid_tx_data", tx_data, 8'h00);
    check("mid_pulses", {alu_start, tx_start}, 2'b00);
    check("mid_flags", {overrun, err}, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_s0 = n_start;
    repeat (30) @(negedge clk);
    check("post_rst_tx", n_tx - n_t0, 1);
    check("post_rst_start", n_start - n_s0, 0);
    check("post_rst_state", state, S_IDLE);

    // Operation resumes after reset
    tx_q.delete(); tx_cyc_q.delete();
    send_byte(8'h0A, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h01, 1'b0);
    wait_state(S_IDLE, 200, ok);
    check("resume_idle", ok, 1);
    check("resume_tx_hi", tx_byte(0), 8'h00);
    check("resume_tx_lo", tx_byte(1), 8'h05);
    check("resume_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 208000: max idle clocks between command bytes (two frames at 9600 baud, 100 MHz).
REQ-002 SHALL have parameter ERR_CODE, default 8'hEE: byte sent in response to a rejected command.
REQ-003 SHALL have ports: clk  in  1  system clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: rx_data  in  8  received byte; rx_valid  in  1  one-cycle pulse, rx_data valid; rx_frame_err  in  1  one-cycle pulse, stop bit bad.
REQ-005 SHALL have ports: alu_a  out  8; alu_b  out  8; alu_op  out  2; alu_start  out  1  one-cycle pulse; alu_done  in  1  one-cycle pulse; alu_result  in  16.
REQ-006 SHALL have ports: tx_data  out  8; tx_start  out  1  one-cycle pulse; tx_busy  in  1  transmitter active.
REQ-007 SHALL have ports: state  out  3  current state encoding; overrun  out  1  sticky, byte dropped while busy; err  out  1  sticky, command rejected.

Function
REQ-008 SHALL accept a 3-byte command on rx_valid pulses, in order operand A, operand B, opcode byte.
REQ-009 SHALL implement states IDLE(0), GET_B(1), GET_OP(2), EXEC(3), WAIT_ALU(4), SEND_HI(5), SEND_LO(6), SEND_ERR(7).
REQ-010 IDLE: rx_valid -> latch alu_a, go GET_B. GET_B: rx_valid -> latch alu_b, go GET_OP.
REQ-011 GET_OP: rx_valid with rx_data[7:2]==0 -> alu_op=rx_data[1:0], go EXEC. Otherwise go SEND_ERR and set err.
REQ-012 EXEC: alu_start high for exactly one cycle, next state WAIT_ALU.
REQ-013 WAIT_ALU: on alu_done, latch alu_result into a 16-bit result register and go SEND_HI. alu_done in any other state is ignored.
REQ-014 SEND_HI/SEND_LO/SEND_ERR: when tx_busy==0 and the send is not yet issued, pulse tx_start one cycle. tx_data is result[15:8], result[7:0] or ERR_CODE respectively, held stable until the state exits.
REQ-015 After a tx_start pulse, SHALL ignore tx_busy for one cycle, then advance on the first tx_busy==0: SEND_HI->SEND_LO, SEND_LO->IDLE, SEND_ERR->IDLE.
REQ-016 Timeout counter SHALL reset on every accepted byte and count only in GET_B/GET_OP. Reaching TIMEOUT_CYCLES-1 -> return to IDLE, discard the partial command, no response, err unchanged.
REQ-017 rx_frame_err in IDLE/GET_B/GET_OP SHALL discard the partial command, set err and go SEND_ERR. A simultaneous rx_valid in the same cycle is ignored.
REQ-018 rx_valid in EXEC..SEND_ERR SHALL drop the byte and set overrun. State is unaffected.
REQ-019 overrun and err SHALL clear only on reset.
REQ-020 Latency: opcode rx_valid edge -> alu_start at +2 cycles. alu_done -> first tx_start at +2 cycles if tx_busy is low.
REQ-021 alu_a/alu_b/alu_op SHALL hold their values from EXEC until the next command's corresponding byte is accepted.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, alu_a/alu_b/tx_data=0, alu_op=0, alu_start/tx_start=0, result=0, timeout counter=0, overrun/err=0.
REQ-023 Reset mid-operation SHALL abort at once, with no further tx_start or alu_start. Operation resumes on the first clk edge after rst_n rises.

Structure
REQ-024 State encodings, ERR_CODE default and the opcode-valid mask SHALL live in shared package uart_alu_pkg.
REQ-025 The timeout counter SHALL be sub-module byte_timeout (inputs clr, en; output expired).

Verification
REQ-026 Bytes 8'h35, 8'h02, 8'h00; ALU returns 16'h0037 two cycles after alu_start -> alu_a=35, alu_b=02, alu_op=0; tx_data 8'h00 then 8'h37; state returns to 0.
REQ-027 Opcode byte 8'h80 -> no alu_start; one tx_start with tx_data=8'hEE; err=1; state 0.
REQ-028 Byte 8'h35, then silence for TIMEOUT_CYCLES -> state 0, no tx_start. Next 3-byte command is processed normally.
REQ-029 rx_valid pulse during WAIT_ALU -> overrun=1; the response to the current command is unchanged.
REQ-030 tx_busy held high 500 cycles during SEND_HI -> tx_start deferred until tx_busy falls. Exactly 2 tx_start pulses total.
REQ-031 rst_n asserted in SEND_LO -> all outputs at reset values in the same cycle. No tx_start after rst_n rises.
